// File: rtl/mc_datapath_if.sv
// Unified instruction/data memory port between the multi-cycle datapath and memory.
// Read data is combinational for the address presented in the same cycle.
interface mc_datapath_if;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_we;
  logic        mem_re;

  modport master (output mem_addr, output mem_wdata, output mem_we, output mem_re,
                  input mem_rdata);
  modport slave  (input mem_addr, input mem_wdata, input mem_we, input mem_re,
                  output mem_rdata);
endinterface

// File: rtl/mc_datapath.sv
// Multi-cycle MIPS datapath: holds PC, IR, MDR, A, B, ALUOut and the register file,
// and executes the per-cycle control bits issued by the multi-cycle control FSM.
module mc_datapath #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        IorD,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        IRwrite,
  input  logic        RegDst,
  input  logic        MemtoReg,
  input  logic        RegWrite,
  input  logic        ALUsrcA,
  input  logic [1:0]  ALUsrcB,
  input  logic [1:0]  ALUop,
  input  logic [1:0]  PCsource,
  input  logic        PCwrite,
  input  logic        PCwriteCond,
  output logic [31:0] Instruction,
  output logic [31:0] pc,
  output logic        zero,
  mc_datapath_if.master mem
);

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  logic [31:0] pcReg, irReg, mdrReg, aReg, bReg, aluOutReg;
  logic [31:0] regFile [32];

  logic [31:0] immExt, srcA, srcB, aluRes, pcNext, rdA, rdB, wrData;
  logic [4:0]  wrReg;
  logic        pcEn;

  assign immExt = {{16{irReg[15]}}, irReg[15:0]};
  assign srcA   = ALUsrcA ? aReg : pcReg;

  always_comb begin
    case (ALUsrcB)
      2'b00:   srcB = bReg;
      2'b01:   srcB = 32'd4;
      2'b10:   srcB = immExt;
      default: srcB = {immExt[29:0], 2'b00};
    endcase
  end

  always_comb begin
    aluRes = srcA + srcB;
    case (ALUop)
      2'b01: aluRes = srcA - srcB;
      2'b10: begin
        case (irReg[5:0])
          FN_ADD:  aluRes = srcA + srcB;
          FN_SUB:  aluRes = srcA - srcB;
          FN_AND:  aluRes = srcA & srcB;
          FN_OR:   aluRes = srcA | srcB;
          FN_SLT:  aluRes = {31'b0, $signed(srcA) < $signed(srcB)};
          default: aluRes = '0;
        endcase
      end
      default: ;
    endcase
  end

  assign zero = (aluRes == '0);

  // Jump target takes the registered IR, so a concurrent IR load never affects it.
  always_comb begin
    case (PCsource)
      2'b00:   pcNext = aluRes;
      2'b01:   pcNext = aluOutReg;
      2'b10:   pcNext = {pcReg[31:28], irReg[25:0], 2'b00};
      default: pcNext = pcReg;
    endcase
  end

  assign pcEn = PCwrite | (PCwriteCond & zero);

  // Register 0 is never written, but is also forced to read 0 explicitly.
  assign rdA    = (irReg[25:21] == 5'd0) ? '0 : regFile[irReg[25:21]];
  assign rdB    = (irReg[20:16] == 5'd0) ? '0 : regFile[irReg[20:16]];
  assign wrReg  = RegDst ? irReg[15:11] : irReg[20:16];
  assign wrData = MemtoReg ? mdrReg : aluOutReg;

  assign Instruction   = irReg;
  assign pc            = pcReg;
  assign mem.mem_addr  = IorD ? aluOutReg : pcReg;
  assign mem.mem_wdata = bReg;
  assign mem.mem_we    = MemWrite;
  assign mem.mem_re    = MemRead;

  always_ff @(posedge clk) begin
    if (rst) begin
      pcReg     <= PC_RESET;
      irReg     <= '0;
      mdrReg    <= '0;
      aReg      <= '0;
      bReg      <= '0;
      aluOutReg <= '0;
      for (int i = 0; i < 32; i++) regFile[i] <= '0;
    end else begin
      mdrReg    <= mem.mem_rdata;
      aReg      <= rdA;
      bReg      <= rdB;
      aluOutReg <= aluRes;
      if (IRwrite) irReg <= mem.mem_rdata;
      if (pcEn) pcReg <= pcNext;
      if (RegWrite && (wrReg != 5'd0)) regFile[wrReg] <= wrData;
    end
  end

endmodule

// File: tb/tb_mc_datapath.sv
// Bench for mc_datapath: acts as control FSM and memory, and compares against an
// instruction-level model of the MIPS subset (add/sub/and/or/slt, lw, sw, beq, j, jr).
module tb_mc_datapath;

  logic        clk = 1'b0;
  logic        rst;
  logic        IorD, MemRead, MemWrite, IRwrite, RegDst, MemtoReg, RegWrite, ALUsrcA;
  logic [1:0]  ALUsrcB, ALUop, PCsource;
  logic        PCwrite, PCwriteCond;
  logic [31:0] Instruction, pc;
  logic        zero;

  mc_datapath_if memBus ();

  logic [31:0] tbMem [4096];
  assign memBus.mem_rdata = tbMem[memBus.mem_addr[13:2]];

  mc_datapath dut (
    .clk(clk), .rst(rst), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
    .IRwrite(IRwrite), .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .ALUsrcA(ALUsrcA), .ALUsrcB(ALUsrcB), .ALUop(ALUop), .PCsource(PCsource),
    .PCwrite(PCwrite), .PCwriteCond(PCwriteCond), .Instruction(Instruction),
    .pc(pc), .zero(zero), .mem(memBus.master)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Architectural model state
  logic [31:0] mRf [32];
  logic [31:0] mPc;
  logic [31:0] mMem [int];

  typedef struct packed {
    logic iorD, memRead, memWrite, irWrite, regDst, memtoReg, regWrite, aluSrcA;
    logic [1:0] aluSrcB, aluOp, pcSource;
    logic pcWrite, pcWriteCond;
  } ctrl_t;

  typedef enum {S_IDLE, S_FETCH, S_DEC, S_REXE, S_RWB, S_ADDR, S_LWMEM, S_LWWB,
                S_SWMEM, S_BEQ, S_J, S_JR} st_t;

  function automatic ctrl_t ctl(input st_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin c.memRead = 1; c.irWrite = 1; c.aluSrcB = 2'b01; c.pcWrite = 1; end
      S_DEC:   c.aluSrcB = 2'b11;
      S_REXE:  begin c.aluSrcA = 1; c.aluOp = 2'b10; end
      S_RWB:   begin c.regDst = 1; c.regWrite = 1; end
      S_ADDR:  begin c.aluSrcA = 1; c.aluSrcB = 2'b10; end
      S_LWMEM: begin c.memRead = 1; c.iorD = 1; end
      S_LWWB:  begin c.memtoReg = 1; c.regWrite = 1; end
      S_SWMEM: begin c.memWrite = 1; c.iorD = 1; end
      S_BEQ:   begin c.aluSrcA = 1; c.aluOp = 2'b01; c.pcWriteCond = 1; c.pcSource = 2'b01; end
      S_J:     begin c.pcWrite = 1; c.pcSource = 2'b10; end
      S_JR:    begin c.aluSrcA = 1; c.pcWrite = 1; end
      default: ;
    endcase
    return c;
  endfunction

  function automatic logic [31:0] rtype(input int rs, input int rt, input int rd,
                                        input logic [5:0] fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input int rs, input int rt,
                                        input logic [15:0] im);
    return {op, 5'(rs), 5'(rt), im};
  endfunction

  function automatic logic [15:0] dOff(input int k);
    return 16'(32'h2000 + 4 * k);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mPc = 32'h0;
    for (int i = 0; i < 32; i++) mRf[i] = '0;
  endtask

  function automatic void setReg(input logic [4:0] r, input logic [31:0] v);
    if (r != 5'd0) mRf[r] = v;
  endfunction

  // One whole instruction at the ISA level.
  function automatic void modelExec(input logic [31:0] ins);
    logic [31:0] a, b, se, ea, nxt, res;
    a   = mRf[ins[25:21]];
    b   = mRf[ins[20:16]];
    se  = {{16{ins[15]}}, ins[15:0]};
    ea  = a + se;
    nxt = mPc + 32'd4;
    case (ins[31:26])
      6'h00: begin
        if (ins[5:0] == 6'h08) nxt = a;
        else begin
          case (ins[5:0])
            6'h20:   res = a + b;
            6'h22:   res = a - b;
            6'h24:   res = a & b;
            6'h25:   res = a | b;
            6'h2a:   res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: res = 32'd0;
          endcase
          setReg(ins[15:11], res);
        end
      end
      6'h23: setReg(ins[20:16], mMem[int'(ea[13:2])]);
      6'h2b: mMem[int'(ea[13:2])] = b;
      6'h04: if (a == b) nxt = mPc + 32'd4 + (se << 2);
      6'h02: nxt = {nxt[31:28], ins[25:0], 2'b00};
      default: ;
    endcase
    mPc = nxt;
  endfunction

  task automatic drive(input ctrl_t c, input logic r);
    rst = r; IorD = c.iorD; MemRead = c.memRead; MemWrite = c.memWrite;
    IRwrite = c.irWrite; RegDst = c.regDst; MemtoReg = c.memtoReg;
    RegWrite = c.regWrite; ALUsrcA = c.aluSrcA; ALUsrcB = c.aluSrcB;
    ALUop = c.aluOp; PCsource = c.pcSource; PCwrite = c.pcWrite;
    PCwriteCond = c.pcWriteCond;
    #1;
    check("mem_we", 32'(memBus.mem_we), 32'(c.memWrite));
    check("mem_re", 32'(memBus.mem_re), 32'(c.memRead));
    if (memBus.mem_we) tbMem[memBus.mem_addr[13:2]] = memBus.mem_wdata;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkState();
    check("pc", pc, mPc);
    for (int i = 0; i < 32; i++) check($sformatf("rf%0d", i), dut.regFile[i], mRf[i]);
  endtask

  task automatic doReset();
    drive(ctl(S_IDLE), 1'b1);
    tick();
    modelReset();
    check("instr_rst", Instruction, 32'h0);
    checkState();
  endtask

  task automatic runInstr(input logic [31:0] ins);
    logic [31:0] a, b, ea;
    a  = mRf[ins[25:21]];
    b  = mRf[ins[20:16]];
    ea = a + {{16{ins[15]}}, ins[15:0]};
    tbMem[mPc[13:2]] = ins;
    drive(ctl(S_FETCH), 0); tick();
    check("ir_fetch", Instruction, ins);
    check("pc_fetch", pc, mPc + 32'd4);
    drive(ctl(S_DEC), 0); tick();
    case (ins[31:26])
      6'h00: begin
        if (ins[5:0] == 6'h08) begin
          drive(ctl(S_JR), 0); tick();
        end else begin
          drive(ctl(S_REXE), 0); tick();
          drive(ctl(S_RWB), 0); tick();
        end
      end
      6'h23: begin
        drive(ctl(S_ADDR), 0); tick();
        drive(ctl(S_LWMEM), 0);
        check("lw_addr", memBus.mem_addr, ea);
        tick();
        drive(ctl(S_LWWB), 0); tick();
      end
      6'h2b: begin
        drive(ctl(S_ADDR), 0); tick();
        drive(ctl(S_SWMEM), 0);
        check("sw_addr", memBus.mem_addr, ea);
        check("sw_wdata", memBus.mem_wdata, b);
        tick();
      end
      6'h04: begin
        drive(ctl(S_BEQ), 0);
        check("beq_zero", 32'(zero), 32'(a == b));
        tick();
      end
      6'h02: begin
        drive(ctl(S_J), 0); tick();
      end
      default: ;
    endcase
    modelExec(ins);
    checkState();
  endtask

  initial begin
    logic [31:0] dv [7];
    logic [5:0]  fns [6];
    logic [31:0] ins;
    ctrl_t       c;
    dv  = '{32'd5, 32'd7, 32'hFFFF_FFFF, 32'h100, 32'h20, 32'h4000_0010, 32'h30};
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h27};
    for (int i = 0; i < 4096; i++) tbMem[i] = '0;
    for (int k = 0; k < 64; k++) begin
      tbMem[12'h800 + k] = (k < 7) ? dv[k] : $urandom;
      mMem[32'h800 + k]  = tbMem[12'h800 + k];
    end

    doReset();
    // Build stale state, then reset it away
    runInstr(itype(6'h23, 0, 9, dOff(0)));
    runInstr(itype(6'h23, 0, 10, dOff(1)));
    runInstr(itype(6'h23, 0, 5, dOff(2)));
    doReset();
    runInstr(32'h012A_4020);

    // R-type set
    runInstr(itype(6'h23, 0, 9, dOff(0)));
    runInstr(itype(6'h23, 0, 10, dOff(1)));
    runInstr(rtype(9, 10, 8, 6'h20));
    check("add_res", dut.regFile[8], 32'd12);
    runInstr(rtype(9, 10, 8, 6'h22));
    check("sub_res", dut.regFile[8], 32'hFFFF_FFFE);
    runInstr(rtype(9, 10, 8, 6'h24));
    runInstr(rtype(9, 10, 8, 6'h25));
    runInstr(itype(6'h23, 0, 9, dOff(2)));
    runInstr(rtype(9, 10, 8, 6'h2a));
    check("slt_res", dut.regFile[8], 32'd1);
    runInstr(rtype(9, 10, 8, 6'h27));

    // sw then lw through the same address
    runInstr(itype(6'h23, 0, 9, dOff(3)));
    runInstr(itype(6'h2b, 9, 10, 16'd8));
    runInstr(itype(6'h23, 9, 11, 16'd8));
    check("lw_res", dut.regFile[11], 32'd7);

    // $0 destination, then $0 as source
    runInstr(rtype(9, 10, 0, 6'h20));
    runInstr(rtype(0, 10, 8, 6'h20));

    // beq taken / not taken from PC 0x20
    runInstr(itype(6'h23, 0, 12, dOff(4)));
    runInstr(rtype(12, 0, 0, 6'h08));
    runInstr(itype(6'h04, 10, 10, 16'd3));
    check("beq_taken", pc, 32'h30);
    runInstr(rtype(12, 0, 0, 6'h08));
    runInstr(itype(6'h04, 9, 10, 16'd3));
    check("beq_not", pc, 32'h24);

    // j keeps upper PC bits
    runInstr(itype(6'h23, 0, 13, dOff(5)));
    runInstr(rtype(13, 0, 0, 6'h08));
    runInstr({6'h02, 26'h000_0040});
    check("j_target", pc, 32'h4000_0100);

    // Random program
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: ins = rtype($urandom_range(0, 15), $urandom_range(0, 15),
                                $urandom_range(0, 15), fns[$urandom_range(0, 5)]);
        4, 5: ins = itype(6'h23, 0, $urandom_range(0, 15), dOff($urandom_range(0, 63)));
        6:    ins = itype(6'h2b, 0, $urandom_range(0, 15), dOff($urandom_range(0, 63)));
        7, 8: ins = itype(6'h04, $urandom_range(0, 7), $urandom_range(0, 7),
                          16'($urandom_range(0, 8)) - 16'd3);
        default: ins = {6'h02, 20'h0, 6'($urandom_range(0, 63))};
      endcase
      runInstr(ins);
    end

    // Reset in the memory cycle of a lw
    runInstr(itype(6'h23, 0, 3, dOff(6)));
    ins = itype(6'h23, 0, 4, dOff(1));
    tbMem[mPc[13:2]] = ins;
    drive(ctl(S_FETCH), 0); tick();
    drive(ctl(S_DEC), 0); tick();
    drive(ctl(S_ADDR), 0); tick();
    drive(ctl(S_LWMEM), 1); tick();
    modelReset();
    check("instr_midrst", Instruction, 32'h0);
    checkState();

    // Reset wins over every enable in the same cycle
    runInstr(itype(6'h23, 0, 3, dOff(6)));
    c = ctl(S_FETCH);
    c.regWrite = 1;
    c.memtoReg = 1;
    drive(c, 1); tick();
    modelReset();
    check("instr_ovr", Instruction, 32'h0);
    checkState();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
